// File: rtl/riscv_mul_wb_buffer.sv
// Writeback buffer for the multi-cycle multiplier: follows each issued op's rd through a
// tag pipeline and queues finished results in a 2-entry FIFO ahead of the writeback port.
module riscv_mul_wb_buffer #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic        flush_i,
  input  logic [31:0] mul_value_i,
  output logic        hold_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o,
  input  logic        wb_ready_i
);

  logic [MUL_LATENCY-1:0] tagValid_q, tagValid_d;
  logic [4:0]             tagRd_q [MUL_LATENCY];
  logic [4:0]             tagRd_d [MUL_LATENCY];

  logic [1:0]  count_q, count_d;
  logic [4:0]  headRd_q, headRd_d, tailRd_q, tailRd_d;
  logic [31:0] headVal_q, headVal_d, tailVal_q, tailVal_d;

  logic advance;
  logic push;
  logic pop;

  // A full FIFO freezes both the tag pipeline and the multiplier, so a push can never overflow it.
  assign hold_o  = (count_q == 2'd2);
  assign advance = ~hold_o;
  assign push    = advance && tagValid_q[MUL_LATENCY-1] && (tagRd_q[MUL_LATENCY-1] != 5'd0);
  assign pop     = (count_q != 2'd0) && wb_ready_i;

  assign wb_valid_o  = (count_q != 2'd0);
  assign wb_rd_idx_o = wb_valid_o ? headRd_q  : 5'd0;
  assign wb_value_o  = wb_valid_o ? headVal_q : 32'd0;

  always_comb begin
    tagValid_d = tagValid_q;
    tagRd_d    = tagRd_q;
    count_d    = count_q;
    headRd_d   = headRd_q;
    headVal_d  = headVal_q;
    tailRd_d   = tailRd_q;
    tailVal_d  = tailVal_q;

    if (advance) begin
      tagValid_d[0] = issue_valid_i;
      tagRd_d[0]    = issue_rd_idx_i;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tagValid_d[i] = tagValid_q[i-1];
        tagRd_d[i]    = tagRd_q[i-1];
      end
    end

    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          headRd_d  = tagRd_q[MUL_LATENCY-1];
          headVal_d = mul_value_i;
        end else begin
          tailRd_d  = tagRd_q[MUL_LATENCY-1];
          tailVal_d = mul_value_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        headRd_d  = tailRd_q;
        headVal_d = tailVal_q;
        count_d   = count_q - 2'd1;
      end
      2'b11: begin
        // With one entry the newcomer becomes head once the old head leaves.
        if (count_q == 2'd1) begin
          headRd_d  = tagRd_q[MUL_LATENCY-1];
          headVal_d = mul_value_i;
        end else begin
          headRd_d  = tailRd_q;
          headVal_d = tailVal_q;
          tailRd_d  = tagRd_q[MUL_LATENCY-1];
          tailVal_d = mul_value_i;
        end
      end
      default: ;
    endcase

    if (flush_i) begin
      tagValid_d = '0;
      count_d    = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tagValid_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tagRd_q[i] <= 5'd0;
      end
      count_q   <= 2'd0;
      headRd_q  <= 5'd0;
      headVal_q <= 32'd0;
      tailRd_q  <= 5'd0;
      tailVal_q <= 32'd0;
    end else begin
      tagValid_q <= tagValid_d;
      tagRd_q    <= tagRd_d;
      count_q    <= count_d;
      headRd_q   <= headRd_d;
      headVal_q  <= headVal_d;
      tailRd_q   <= tailRd_d;
      tailVal_q  <= tailVal_d;
    end
  end

endmodule

// File: tb/tb_riscv_mul_wb_buffer.sv
// Self-checking bench for riscv_mul_wb_buffer: a directed vector table, hand-written corner
// sequences, and random traffic scored against an in-order queue of expected results.
module tb_riscv_mul_wb_buffer;

  localparam int L = 2;

  logic        clk_i;
  logic        rst_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_idx_i;
  logic        flush_i;
  logic [31:0] mul_value_i;
  logic        hold_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_value_o;
  logic        wb_ready_i;

  riscv_mul_wb_buffer #(.MUL_LATENCY(L)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_rd_idx_i (issue_rd_idx_i),
    .flush_i        (flush_i),
    .mul_value_i    (mul_value_i),
    .hold_o         (hold_o),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_idx_o    (wb_rd_idx_o),
    .wb_value_o     (wb_value_o),
    .wb_ready_i     (wb_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } res_t;

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        rdy;
    logic        expValid;
    logic [4:0]  expRd;
    logic [31:0] expVal;
    logic        expHold;
  } vec_t;

  res_t        expQ[$];
  int          popCycles[$];
  int          checks = 0;
  int          passes = 0;
  int          popCount = 0;
  int          cycleCnt = 0;
  logic [31:0] issueValue;
  logic [31:0] mulPipe [L];
  vec_t        vecs [11];

  // Stand-in for the multiplier: the issued value emerges L advancing cycles later.
  assign mul_value_i = mulPipe[L-1];

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < L; i++) mulPipe[i] <= 32'd0;
    end else if (!hold_o) begin
      mulPipe[0] <= issueValue;
      for (int i = 1; i < L; i++) mulPipe[i] <= mulPipe[i-1];
    end
  end

  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
  endtask

  // Scoreboard: every accepted result must match the oldest outstanding non-zero-rd issue.
  always @(negedge clk_i) begin
    if (!wb_valid_o) begin
      checkOutput("idleRdZero", {27'd0, wb_rd_idx_o}, 32'd0);
      checkOutput("idleValZero", wb_value_o, 32'd0);
    end else if (rst_i && wb_ready_i && !flush_i) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResultRd", {27'd0, wb_rd_idx_o}, 32'd0);
      end else begin
        res_t e;
        e = expQ.pop_front();
        checkOutput("popRd", {27'd0, wb_rd_idx_o}, {27'd0, e.rd});
        checkOutput("popVal", wb_value_o, e.val);
      end
      popCount++;
      popCycles.push_back(cycleCnt);
    end
  end

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] rd, input logic [31:0] val, input logic rdy);
    issue_valid_i  = iv;
    issue_rd_idx_i = rd;
    issueValue     = iv ? val : 32'd0;
    wb_ready_i     = rdy;
    if (iv && rd != 5'd0 && !hold_o && !flush_i) expQ.push_back('{rd: rd, val: val});
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      if (expQ.size() == 0 && !wb_valid_o) done = 1;
      else stepCycle();
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int startPops;
    bit holdSeen;

    vecs[0]  = '{1'b1, 5'd5, 32'h0000_0C35, 1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 5'd5, 32'h0000_0C35,  1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[5]  = '{1'b1, 5'd0, 32'h0000_0111, 1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[6]  = '{1'b1, 5'd7, 32'h0000_0777, 1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 5'd0, 32'd0,          1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b1, 5'd7, 32'h0000_0777,  1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'd0,         1'b1, 1'b0, 5'd0, 32'd0,          1'b0};

    rst_i = 1'b0;
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    issue_rd_idx_i = 5'd0;
    issueValue = 32'd0;
    wb_ready_i = 1'b0;
    #1;
    checkOutput("resetValid", {31'd0, wb_valid_o}, 32'd0);
    checkOutput("resetHold", {31'd0, hold_o}, 32'd0);
    checkOutput("resetRd", {27'd0, wb_rd_idx_o}, 32'd0);
    checkOutput("resetVal", wb_value_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    stepCycle();

    $display("[TB] single op latency and rd=0 drop table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].rd, vecs[i].val, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, wb_valid_o}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_rd", i), {27'd0, wb_rd_idx_o}, {27'd0, vecs[i].expRd});
      checkOutput($sformatf("vec%0d_val", i), wb_value_o, vecs[i].expVal);
      checkOutput($sformatf("vec%0d_hold", i), {31'd0, hold_o}, {31'd0, vecs[i].expHold});
      stepCycle();
    end

    $display("[TB] back-pressure");
    startPops = popCount;
    applyStimulus(1'b1, 5'd1, 32'hAAAA_0001, 1'b0); stepCycle();
    applyStimulus(1'b1, 5'd2, 32'hAAAA_0002, 1'b0); stepCycle();
    applyStimulus(1'b1, 5'd3, 32'hAAAA_0003, 1'b0); stepCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("bpHoldOneEntry", {31'd0, hold_o}, 32'd0);
    checkOutput("bpHeadRd", {27'd0, wb_rd_idx_o}, 32'd1);
    stepCycle();
    checkOutput("bpHoldFull", {31'd0, hold_o}, 32'd1);
    checkOutput("bpHeadVal", wb_value_o, 32'hAAAA_0001);
    repeat (3) stepCycle();
    checkOutput("bpHoldStays", {31'd0, hold_o}, 32'd1);
    drain("bpDrain");
    checkOutput("bpPopCount", popCount - startPops, 32'd3);

    $display("[TB] streaming");
    startPops = popCount;
    popCycles.delete();
    holdSeen = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
      if (hold_o) holdSeen = 1;
      stepCycle();
    end
    for (int i = 0; i < L + 2; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      if (hold_o) holdSeen = 1;
      stepCycle();
    end
    drain("streamDrain");
    checkOutput("streamNoHold", {31'd0, holdSeen}, 32'd0);
    checkOutput("streamCount", popCount - startPops, 32'd50);
    if (popCycles.size() >= 50) checkOutput("streamSpan", popCycles[49] - popCycles[0], 32'd49);
    else checkOutput("streamSpanSize", popCycles.size(), 32'd50);

    $display("[TB] flush");
    startPops = popCount;
    applyStimulus(1'b1, 5'd4, 32'hBBBB_0004, 1'b0); stepCycle();
    applyStimulus(1'b1, 5'd5, 32'hBBBB_0005, 1'b0); stepCycle();
    applyStimulus(1'b1, 5'd6, 32'hBBBB_0006, 1'b0); stepCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0); stepCycle();
    checkOutput("flushPreHold", {31'd0, hold_o}, 32'd1);
    flush_i = 1'b1;
    applyStimulus(1'b1, 5'd8, 32'hBBBB_0008, 1'b0);
    expQ.delete();
    stepCycle();
    flush_i = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("flushValid", {31'd0, wb_valid_o}, 32'd0);
    checkOutput("flushHold", {31'd0, hold_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      stepCycle();
    end
    checkOutput("flushNoResults", popCount - startPops, 32'd0);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 5'd10, 32'hCCCC_000A, 1'b0); stepCycle();
    applyStimulus(1'b1, 5'd11, 32'hCCCC_000B, 1'b0); stepCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle(); stepCycle();
    checkOutput("rstPreHold", {31'd0, hold_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    expQ.delete();
    checkOutput("rstValid", {31'd0, wb_valid_o}, 32'd0);
    checkOutput("rstHold", {31'd0, hold_o}, 32'd0);
    checkOutput("rstRd", {27'd0, wb_rd_idx_o}, 32'd0);
    checkOutput("rstVal", wb_value_o, 32'd0);
    stepCycle();
    rst_i = 1'b1;
    applyStimulus(1'b1, 5'd9, 32'hCCCC_0009, 1'b1);
    checkOutput("postRstIdle", {31'd0, wb_valid_o}, 32'd0);
    stepCycle();
    for (int k = 1; k <= L; k++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      checkOutput($sformatf("postRstWait%0d", k), {31'd0, wb_valid_o}, 32'd0);
      stepCycle();
    end
    checkOutput("postRstValid", {31'd0, wb_valid_o}, 32'd1);
    checkOutput("postRstRd", {27'd0, wb_rd_idx_o}, 32'd9);
    checkOutput("postRstVal", wb_value_o, 32'hCCCC_0009);
    stepCycle();
    drain("postRstDrain");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0) && !hold_o, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 2) != 0);
      stepCycle();
    end
    drain("randomDrain");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
